// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Strobe bundle order is {ce, oe, we, lb, ub}, all active-low.
    localparam logic [4:0] STROBE_OFF = 5'b11111;

    typedef struct packed {
        logic ce;
        logic oe;
        logic we;
        logic lb;
        logic ub;
    } strobe_t;

    function automatic strobe_t active_strobes(logic oe_n, logic we_n, logic [1:0] be);
        return '{ce: 1'b0, oe: oe_n, we: we_n, lb: ~be[0], ub: ~be[1]};
    endfunction

    function automatic logic [15:0] merge_bytes(logic [15:0] old_word, logic [15:0] new_word,
                                                logic [1:0] be);
        return {be[1] ? new_word[15:8] : old_word[15:8],
                be[0] ? new_word[7:0]  : old_word[7:0]};
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: both ports' request, data and completion signals.
interface sram_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        be0;
    logic [1:0]        be1;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, be0, be1,
        input  ack, rdata0, rdata1
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, be0, be1,
        output ack, rdata0, rdata1
    );
endinterface

// File: rtl/sram_arbiter_rr_arbiter2.sv
// Two-way round-robin winner select; on a tie the port that did not win last time wins.
module rr_arbiter2
    import sram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else begin
            winner = req[1] ? PORT_DBG : PORT_CPU;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for an asynchronous 16-bit SRAM: serialises CPU and debug accesses,
// generates registered active-low strobes and owns the DQ tristate.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_arbiter_if.slave     bus,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_we,
    output logic              sram_lb,
    output logic              sram_ub,
    output logic [ADDR_W-1:0] sram_addr,
    inout  tri   [DATA_W-1:0] sram_dq
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              winner_q;
    logic              last_grant;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        be_q;
    logic              drive_q;
    strobe_t           strb;
    logic [1:0]        ack_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              arb_valid;
    logic              arb_winner;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [1:0]        be_sel;

    rr_arbiter2 u_arb (
        .req        (bus.req),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign addr_sel  = arb_winner ? bus.addr1  : bus.addr0;
    assign wdata_sel = arb_winner ? bus.wdata1 : bus.wdata0;
    assign be_sel    = arb_winner ? bus.be1    : bus.be0;

    // Strobes are set on the transition into each state so every pin comes from a flop.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            winner_q   <= PORT_CPU;
            last_grant <= PORT_DBG;
            sram_addr  <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            drive_q    <= 1'b0;
            strb       <= strobe_t'(STROBE_OFF);
            ack_q      <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            ack_q <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        winner_q  <= arb_winner;
                        sram_addr <= addr_sel;
                        wdata_q   <= wdata_sel;
                        be_q      <= be_sel;
                        cnt       <= CNT_W'(WAIT_CYCLES);
                        if (bus.we[arb_winner]) begin
                            state   <= WR_SETUP;
                            strb    <= active_strobes(1'b1, 1'b1, be_sel);
                            drive_q <= 1'b1;
                        end else begin
                            state <= READ;
                            strb  <= active_strobes(1'b0, 1'b1, be_sel);
                        end
                    end
                end
                READ: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (winner_q == PORT_DBG) begin
                            rdata1_q <= merge_bytes(rdata1_q, sram_dq, be_q);
                        end else begin
                            rdata0_q <= merge_bytes(rdata0_q, sram_dq, be_q);
                        end
                        strb            <= strobe_t'(STROBE_OFF);
                        ack_q[winner_q] <= 1'b1;
                        state           <= DONE;
                    end
                end
                WR_SETUP: begin
                    cnt     <= CNT_W'(WAIT_CYCLES);
                    strb.we <= 1'b0;
                    state   <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        strb.we <= 1'b1;
                        state   <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    strb            <= strobe_t'(STROBE_OFF);
                    drive_q         <= 1'b0;
                    ack_q[winner_q] <= 1'b1;
                    state           <= DONE;
                end
                DONE: begin
                    last_grant <= winner_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sram_ce = strb.ce;
    assign sram_oe = strb.oe;
    assign sram_we = strb.we;
    assign sram_lb = strb.lb;
    assign sram_ub = strb.ub;
    assign sram_dq = drive_q ? wdata_q : 'z;

    assign bus.ack    = ack_q;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

endmodule
